spi_master_driver: RTL and testbench

SPI_MASTER_DRIVER -- requirements
Module: spi_master_driver

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_shift_reg.sv | 45 ++++
 rtl/spi_master_driver.sv | 147 ++++++++++++++
 tb/tb_spi_master_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: FSM state encoding and frame command codes,
// used by the master driver and the slave-side bench.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StHold,
    StWait,
    StCapt,
    StEnd
  } spi_state_e;

  localparam logic [1:0] CmdWrAddr = 2'b00;
  localparam logic [1:0] CmdWrData = 2'b01;
  localparam logic [1:0] CmdRdAddr = 2'b10;
  localparam logic [1:0] CmdRdData = 2'b11;

  // Last bit-counter value in each counted state.
  localparam logic [3:0] ShiftLast = 4'd9;
  localparam logic [3:0] CaptLast  = 4'd7;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial datapath: 10-bit {cmd,din} word shifted out MSB first and an 8-bit
// MISO shift-in register.
module spi_shift_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [9:0] word_i,
  input  logic       shift_out_i,
  input  logic       shift_in_i,
  input  logic       miso_i,
  output logic       tx_msb_o,
  output logic [7:0] rx_next_o
);

  logic [9:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;

  always_comb begin
    tx_d = tx_q;
    if (load_i) begin
      tx_d = word_i;
    end else if (shift_out_i) begin
      tx_d = {tx_q[8:0], 1'b0};
    end
    rx_d = rx_q;
    if (shift_in_i) begin
      rx_d = {rx_q[6:0], miso_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign tx_msb_o  = tx_q[9];
  // Next value lets the top commit all 8 captured bits on the final sample edge.
  assign rx_next_o = rx_d;

endmodule

// File: rtl/spi_master_driver.sv
// SPI master frame driver: sends {cmd,din} MSB first after a command-check bit
// and, on rd-data frames, waits RD_WAIT cycles then captures one byte from MISO.
module spi_master_driver
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [1:0] cmd_i,
  input  logic [7:0] din_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rd_data_o,
  output logic       ss_n_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam logic [3:0] WaitLast = 4'(RD_WAIT - 1);

  spi_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       load, shift_out, shift_in, tx_msb;
  logic [7:0] rx_next;

  spi_shift_reg u_shift_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .word_i      ({cmd_i, din_i}),
    .shift_out_i (shift_out),
    .shift_in_i  (shift_in),
    .miso_i      (miso_i),
    .tx_msb_o    (tx_msb),
    .rx_next_o   (rx_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    rd_data_d = rd_data_q;
    load      = 1'b0;
    shift_in  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StPre;
          cmd_d   = cmd_i;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StPre: begin
        state_d = StShift;
        cnt_d   = '0;
      end
      StShift: begin
        if (cnt_q == ShiftLast) begin
          cnt_d = '0;
          if (cmd_q != CmdRdData) begin
            state_d = StHold;
          end else if (RD_WAIT == 0) begin
            state_d = StCapt;
          end else begin
            state_d = StWait;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHold: state_d = StEnd;
      StWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          state_d = StCapt;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCapt: begin
        shift_in = 1'b1;
        if (cnt_q == CaptLast) begin
          cnt_d     = '0;
          rd_data_d = rx_next;
          state_d   = StEnd;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so the registers track the state.
    shift_out = (state_d == StShift);
    ss_n_d    = (state_d == StIdle) || (state_d == StEnd);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StEnd);
    if (state_d == StPre) begin
      mosi_d = cmd_i[1];
    end else if (state_d == StShift) begin
      mosi_d = tx_msb;
    end else begin
      mosi_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_q     <= '0;
      rd_data_q <= '0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_data_o = rd_data_q;
  assign ss_n_o    = ss_n_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: expected MOSI frames are queued at start and
// compared against the bits seen while SS_n is low; the bench plays the slave.
module tb_spi_master_driver;
  import spi_pkg::*;

  localparam int RdWait = 2;
  localparam int WrLen  = 12;
  localparam int RdLen  = 11 + RdWait + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic       miso = 1'b0;
  logic       busy, done, ss_n, mosi;
  logic [7:0] rd_data;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];
  logic obs_q[$];

  always #5 clk = ~clk;

  spi_master_driver #(.RD_WAIT(RdWait)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .cmd_i     (cmd),
    .din_i     (din),
    .busy_o    (busy),
    .done_o    (done),
    .rd_data_o (rd_data),
    .ss_n_o    (ss_n),
    .mosi_o    (mosi),
    .miso_i    (miso)
  );

  function automatic void push_expected(input logic [1:0] c, input logic [7:0] d);
    logic [9:0] w;
    w = {c, d};
    exp_q.push_back(c[1]);
    for (int i = 9; i >= 0; i--) exp_q.push_back(w[i]);
    if (c == CmdRdData) begin
      for (int i = 0; i < RdWait + 8; i++) exp_q.push_back(1'b0);
    end else begin
      exp_q.push_back(1'b0);
    end
  endfunction

  function automatic int pop_mismatches(input int n);
    int   mm;
    logic e, o;
    mm = 0;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
      if (o !== e) mm++;
    end
    return mm;
  endfunction

  task automatic issue_start(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    cmd   = c;
    din   = d;
    push_expected(c, d);
  endtask

  // Records MOSI while SS_n is low, acting as slave on MISO; returns at the
  // first cycle with SS_n high again (END, or the cycle after a reset).
  task automatic capture_frame(input logic [7:0] miso_byte, input int is_rd,
                               input int inject_at, input int rst_at,
                               output int pre_wait, output int low_len,
                               output logic end_done, output logic end_busy);
    int k;
    obs_q.delete();
    pre_wait = 0;
    @(negedge clk);
    start = 1'b0;
    while (ss_n !== 1'b0 && pre_wait < 50) begin
      @(negedge clk);
      pre_wait++;
    end
    k = 0;
    while (ss_n === 1'b0 && k < 100) begin
      obs_q.push_back(mosi);
      if (is_rd != 0 && k >= 11 + RdWait && k < 19 + RdWait) begin
        miso = miso_byte[7 - (k - 11 - RdWait)];
      end else begin
        miso = 1'b0;
      end
      if (k == inject_at) begin
        start = 1'b1;
        cmd   = CmdWrData;
        din   = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (k == rst_at) rst_n = 1'b0;
      k++;
      @(negedge clk);
    end
    start    = 1'b0;
    miso     = 1'b0;
    low_len  = k;
    end_done = done;
    end_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ss_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n: got %b want 1", ss_n); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (rd_data !== 8'h00) begin
      failures++; $display("FAIL reset_rd_data: got %h want 00", rd_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ss_n !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: ss_n=%b busy=%b want 1/0", ss_n, busy);
    end
  endtask

  task automatic test_wr_addr();
    int pw, len, mm;
    logic ed, eb;
    logic [9:0] rx;
    issue_start(CmdWrAddr, 8'hA5);
    capture_frame(8'h00, 0, -1, -1, pw, len, ed, eb);
    rx = 10'h3FF;
    if (obs_q.size() >= 11) for (int i = 1; i <= 10; i++) rx = {rx[8:0], obs_q[i]};
    checks++; if (len != WrLen) begin failures++; $display("FAIL wr_addr_len: got %0d want %0d", len, WrLen); end
    checks++; if (rx !== 10'h0A5) begin failures++; $display("FAIL wr_addr_rx: got %h want 0a5", rx); end
    mm = pop_mismatches(WrLen);
    checks++; if (mm != 0) begin failures++; $display("FAIL wr_addr_mosi: got %0d bad bits want 0", mm); end
    checks++; if (ed !== 1'b1 || eb !== 1'b1) begin
      failures++; $display("FAIL wr_addr_end: done=%b busy=%b want 1/1", ed, eb);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL wr_addr_after: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_rd_data();
    int pw, len, mm;
    logic ed, eb;
    issue_start(CmdRdData, 8'h00);
    capture_frame(8'h3C, 1, -1, -1, pw, len, ed, eb);
    checks++; if (len != RdLen) begin failures++; $display("FAIL rd_len: got %0d want %0d", len, RdLen); end
    mm = pop_mismatches(RdLen);
    checks++; if (mm != 0) begin failures++; $display("FAIL rd_mosi: got %0d bad bits want 0", mm); end
    checks++; if (ed !== 1'b1) begin failures++; $display("FAIL rd_done: got %b want 1", ed); end
    checks++; if (rd_data !== 8'h3C) begin failures++; $display("FAIL rd_data: got %h want 3c", rd_data); end
  endtask

  task automatic test_write_frames();
    logic [1:0] tc[3] = '{CmdWrData, CmdRdAddr, CmdWrAddr};
    logic [7:0] td[3] = '{8'h3C, 8'h81, 8'h5A};
    int pw, len, mm;
    logic ed, eb;
    for (int t = 0; t < 3; t++) begin
      issue_start(tc[t], td[t]);
      capture_frame(8'hC3, 0, -1, -1, pw, len, ed, eb);
      checks++; if (len != WrLen) begin failures++; $display("FAIL wr_len[%0d]: got %0d want %0d", t, len, WrLen); end
      mm = pop_mismatches(WrLen);
      checks++; if (mm != 0) begin failures++; $display("FAIL wr_mosi[%0d]: got %0d bad bits want 0", t, mm); end
      checks++; if (ed !== 1'b1) begin failures++; $display("FAIL wr_done[%0d]: got %b want 1", t, ed); end
      checks++;
      if (rd_data !== 8'h3C) begin
        failures++; $display("FAIL wr_keeps_rd_data[%0d]: got %h want 3c", t, rd_data);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int pw, len, mm, extra;
    logic ed, eb;
    issue_start(CmdRdAddr, 8'h96);
    capture_frame(8'h00, 0, 4, -1, pw, len, ed, eb);
    checks++; if (len != WrLen) begin failures++; $display("FAIL ignore_len: got %0d want %0d", len, WrLen); end
    mm = pop_mismatches(WrLen);
    checks++; if (mm != 0) begin failures++; $display("FAIL ignore_mosi: got %0d bad bits want 0", mm); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ss_n !== 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_no_frame: got %0d low cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int pw, len, mm;
    logic ed, eb;
    issue_start(CmdWrData, 8'hC3);
    capture_frame(8'h00, 0, -1, -1, pw, len, ed, eb);
    mm = pop_mismatches(WrLen);
    checks++; if (mm != 0 || ed !== 1'b1) begin
      failures++; $display("FAIL b2b_first: got %0d bad bits done=%b want 0/1", mm, ed);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ss_n !== 1'b1) begin
      failures++; $display("FAIL b2b_gap: busy=%b ss_n=%b want 0/1", busy, ss_n);
    end
    start = 1'b1;
    cmd   = CmdWrAddr;
    din   = 8'h5A;
    push_expected(CmdWrAddr, 8'h5A);
    capture_frame(8'h00, 0, -1, -1, pw, len, ed, eb);
    checks++; if (pw != 0) begin failures++; $display("FAIL b2b_pre: got %0d extra high cycles want 0", pw); end
    checks++; if (len != WrLen) begin failures++; $display("FAIL b2b_len: got %0d want %0d", len, WrLen); end
    mm = pop_mismatches(WrLen);
    checks++; if (mm != 0) begin failures++; $display("FAIL b2b_mosi: got %0d bad bits want 0", mm); end
  endtask

  task automatic test_mid_frame_reset();
    int pw, len, mm, pulses;
    logic ed, eb;
    @(negedge clk);
    issue_start(CmdRdData, 8'h00);
    capture_frame(8'hFF, 1, -1, 6, pw, len, ed, eb);
    checks++; if (len != 7) begin failures++; $display("FAIL rst_abort_len: got %0d want 7", len); end
    mm = pop_mismatches(7);
    exp_q.delete();
    checks++; if (mm != 0) begin failures++; $display("FAIL rst_abort_mosi: got %0d bad bits want 0", mm); end
    checks++; if (ed !== 1'b0) begin failures++; $display("FAIL rst_abort_done: got %b want 0", ed); end
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done !== 1'b0 || ss_n !== 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rst_quiet: got %0d active cycles want 0", pulses); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_wr_addr();
    test_rd_data();
    test_write_frames();
    test_busy_ignore();
    test_back_to_back();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
